// File: rtl/traffic_phase_controller_pkg.sv
// Shared encodings for the intersection controller: light codes, phase states,
// the side that gets green after a walk phase, and the state-to-lamp decode.
package traffic_phase_controller_pkg;

   typedef enum logic [1:0] {
      LIGHT_GREEN  = 2'b00,
      LIGHT_YELLOW = 2'b01,
      LIGHT_RED    = 2'b10
   } light_t;

   typedef enum logic [2:0] {
      ST_AG   = 3'd0,
      ST_AY   = 3'd1,
      ST_BG   = 3'd2,
      ST_BY   = 3'd3,
      ST_WALK = 3'd4
   } state_t;

   typedef enum logic {
      SIDE_A = 1'b0,
      SIDE_B = 1'b1
   } side_t;

   typedef struct packed {
      light_t la;
      light_t lb;
      logic   walk;
   } lamps_t;

   // Any state outside the legal set decodes to all-red so the lamps stay safe.
   function automatic lamps_t decode_lamps(input state_t st);
      lamps_t l;
      l.la   = LIGHT_RED;
      l.lb   = LIGHT_RED;
      l.walk = 1'b0;
      case (st)
         ST_AG:   l.la   = LIGHT_GREEN;
         ST_AY:   l.la   = LIGHT_YELLOW;
         ST_BG:   l.lb   = LIGHT_GREEN;
         ST_BY:   l.lb   = LIGHT_YELLOW;
         ST_WALK: l.walk = 1'b1;
         default: ;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/traffic_phase_controller_phase_timer.sv
// Shared phase timer: counts cycles spent in the current phase, clears when the
// phase changes and holds at MAX_COUNT-1 so a long idle green never wraps.
module traffic_phase_controller_phase_timer #(
   parameter int MAX_COUNT = 30,
   parameter int W         = $clog2(MAX_COUNT)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] COUNT_LAST = W'(MAX_COUNT - 1);

   logic [W-1:0] count_d;
   logic [W-1:0] count_q;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (count_q != COUNT_LAST) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/traffic_phase_controller.sv
// Two-street intersection sequencer with a latched pedestrian walk phase.
// Greens yield after MIN_GREEN when the own street is empty, or at MAX_GREEN for fairness.
module traffic_phase_controller
   import traffic_phase_controller_pkg::*;
#(
   parameter int MIN_GREEN     = 10,
   parameter int MAX_GREEN     = 30,
   parameter int YELLOW_CYCLES = 5,
   parameter int WALK_CYCLES   = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       TA,
   input  logic       TB,
   input  logic       P,
   output logic [1:0] LA,
   output logic [1:0] LB,
   output logic       walk,
   output logic [2:0] state_dbg
);

   localparam int TW = $clog2(MAX_GREEN);

   localparam logic [TW-1:0] MIN_LAST    = TW'(MIN_GREEN - 1);
   localparam logic [TW-1:0] MAX_LAST    = TW'(MAX_GREEN - 1);
   localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_CYCLES - 1);
   localparam logic [TW-1:0] WALK_LAST   = TW'(WALK_CYCLES - 1);

   state_t        state_d;
   state_t        state_q;
   logic          ped_pending_d;
   logic          ped_pending_q;
   side_t         next_side_d;
   side_t         next_side_q;
   logic [TW-1:0] timer;
   logic          want_a;
   logic          want_b;
   logic          enter_walk;
   lamps_t        lamps;

   traffic_phase_controller_phase_timer #(
      .MAX_COUNT (MAX_GREEN),
      .W         (TW)
   ) u_phase_timer (
      .clk   (clk),
      .reset (reset),
      .clr   (state_d != state_q),
      .count (timer)
   );

   assign want_a     = TB | ped_pending_q;
   assign want_b     = TA | ped_pending_q;
   assign enter_walk = (state_d == ST_WALK) && (state_q != ST_WALK);

   // State register together with the two flops that only move with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_AG;
         ped_pending_q <= 1'b0;
         next_side_q   <= SIDE_B;
      end else begin
         state_q       <= state_d;
         ped_pending_q <= ped_pending_d;
         next_side_q   <= next_side_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_AG: begin
            if (want_a && (((timer >= MIN_LAST) && !TA) || (timer == MAX_LAST))) begin
               state_d = ST_AY;
            end
         end
         ST_AY: begin
            if (timer == YELLOW_LAST) begin
               state_d = ped_pending_q ? ST_WALK : ST_BG;
            end
         end
         ST_BG: begin
            if (want_b && (((timer >= MIN_LAST) && !TB) || (timer == MAX_LAST))) begin
               state_d = ST_BY;
            end
         end
         ST_BY: begin
            if (timer == YELLOW_LAST) begin
               state_d = ped_pending_q ? ST_WALK : ST_AG;
            end
         end
         ST_WALK: begin
            if (timer == WALK_LAST) begin
               state_d = (next_side_q == SIDE_A) ? ST_AG : ST_BG;
            end
         end
         default: state_d = ST_AG;
      endcase
   end

   // Clearing on walk entry wins, so a press on that same edge is dropped;
   // the green after the walk goes to the street that did not just have it.
   always_comb begin
      ped_pending_d = ped_pending_q;
      next_side_d   = next_side_q;
      if (enter_walk) begin
         ped_pending_d = 1'b0;
         next_side_d   = (state_q == ST_AY) ? SIDE_B : SIDE_A;
      end else if (P && (state_q != ST_WALK)) begin
         ped_pending_d = 1'b1;
      end
   end

   always_comb begin
      lamps     = decode_lamps(state_q);
      LA        = lamps.la;
      LB        = lamps.lb;
      walk      = lamps.walk;
      state_dbg = state_q;
   end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for the intersection controller with short phase lengths
// (MIN 4, MAX 8, YELLOW 2, WALK 3); expected lamp codes are worked out by hand.
module tb_traffic_phase_controller;

   // {LA, LB, walk}
   localparam logic [4:0] AG_C = 5'b00_10_0;
   localparam logic [4:0] AY_C = 5'b01_10_0;
   localparam logic [4:0] BG_C = 5'b10_00_0;
   localparam logic [4:0] BY_C = 5'b10_01_0;
   localparam logic [4:0] WK_C = 5'b10_10_1;

   logic       clk = 1'b0;
   logic       reset;
   logic       TA;
   logic       TB;
   logic       P;
   logic [1:0] LA;
   logic [1:0] LB;
   logic       walk;
   logic [2:0] state_dbg;

   int n_cmp = 0;
   int n_bad = 0;
   logic [4:0] exp_q[$];

   traffic_phase_controller #(
      .MIN_GREEN     (4),
      .MAX_GREEN     (8),
      .YELLOW_CYCLES (2),
      .WALK_CYCLES   (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .TA        (TA),
      .TB        (TB),
      .P         (P),
      .LA        (LA),
      .LB        (LB),
      .walk      (walk),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [4:0] lamps();
      return {LA, LB, walk};
   endfunction

   // One rising edge, then sample 1 ns later; every cycle also checks the
   // no-conflict rule: one light red, and walk only with both red.
   task automatic tick();
      logic safe;
      @(posedge clk);
      #1;
      safe = ((LA == 2'b10) || (LB == 2'b10)) && (!walk || ((LA == 2'b10) && (LB == 2'b10)));
      check_eq("safety", {4'b0000, safe}, 5'b00001);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      TA    = 1'b0;
      TB    = 1'b0;
      P     = 1'b0;

      // Only street A has traffic: A green holds.
      TA = 1'b1; TB = 1'b0;
      do_reset();
      check_eq("reset_state", lamps(), AG_C);
      for (int i = 0; i < 20; i++) begin
         tick();
         check_eq("a_only_hold", lamps(), AG_C);
      end

      // Only street B: A yields after min green.
      TA = 1'b0; TB = 1'b1;
      do_reset();
      ticks(3); check_eq("tb_e3_ag", lamps(), AG_C);
      tick();   check_eq("tb_e4_ay", lamps(), AY_C);
      tick();   check_eq("tb_e5_ay", lamps(), AY_C);
      tick();   check_eq("tb_e6_bg", lamps(), BG_C);

      // Both streets busy: 8 green / 2 yellow alternation, period 20.
      TA = 1'b1; TB = 1'b1;
      do_reset();
      for (int k = 0; k < 40; k++) begin
         int ph;
         ph = k % 20;
         if (ph < 8)       exp_q.push_back(AG_C);
         else if (ph < 10) exp_q.push_back(AY_C);
         else if (ph < 18) exp_q.push_back(BG_C);
         else              exp_q.push_back(BY_C);
      end
      for (int k = 0; k < 40; k++) begin
         if (k > 0) tick();
         check_eq("both_alternate", lamps(), exp_q.pop_front());
      end

      // Single-cycle pedestrian pulse latched on edge 2.
      TA = 1'b1; TB = 1'b0; P = 1'b0;
      do_reset();
      tick();
      P = 1'b1; tick(); P = 1'b0;
      ticks(5); check_eq("ped_e7_ag", lamps(), AG_C);
      tick();   check_eq("ped_e8_ay", lamps(), AY_C);
      tick();   check_eq("ped_e9_ay", lamps(), AY_C);
      tick();   check_eq("ped_e10_walk", lamps(), WK_C);
      tick();   check_eq("ped_e11_walk", lamps(), WK_C);
      tick();   check_eq("ped_e12_walk", lamps(), WK_C);
      tick();   check_eq("ped_e13_bg", lamps(), BG_C);

      // P held high up to the end of walk: exactly one walk phase.
      TA = 1'b1; TB = 1'b0;
      do_reset();
      P = 1'b1;
      ticks(9); check_eq("hold_e9_ay", lamps(), AY_C);
      tick();   check_eq("hold_e10_walk", lamps(), WK_C);
      ticks(3); check_eq("hold_e13_bg", lamps(), BG_C);
      P = 1'b0;
      ticks(4); check_eq("hold_e17_by", lamps(), BY_C);
      ticks(2); check_eq("hold_e19_ag", lamps(), AG_C);
      ticks(15); check_eq("hold_no_second_walk", lamps(), AG_C);

      // Reset while in walk.
      TA = 1'b1; TB = 1'b0; P = 1'b0;
      do_reset();
      tick();
      P = 1'b1; tick(); P = 1'b0;
      ticks(9); check_eq("rw_e11_walk", lamps(), WK_C);
      P = 1'b1;
      reset = 1'b1; tick(); reset = 1'b0; P = 1'b0;
      check_eq("rw_after_reset", lamps(), AG_C);
      ticks(20); check_eq("rw_no_walk", lamps(), AG_C);

      // Reset while a request is pending drops it.
      TA = 1'b1; TB = 1'b0; P = 1'b0;
      do_reset();
      tick();
      P = 1'b1; tick(); P = 1'b0;
      do_reset();
      check_eq("lost_reset", lamps(), AG_C);
      ticks(12); check_eq("lost_still_ag", lamps(), AG_C);

      // Walk out of B yellow returns green to A.
      TA = 1'b0; TB = 1'b1; P = 1'b0;
      do_reset();
      ticks(6); check_eq("bw_e6_bg", lamps(), BG_C);
      P = 1'b1; tick(); P = 1'b0;
      ticks(6); check_eq("bw_e13_bg", lamps(), BG_C);
      tick();   check_eq("bw_e14_by", lamps(), BY_C);
      tick();   check_eq("bw_e15_by", lamps(), BY_C);
      tick();   check_eq("bw_e16_walk", lamps(), WK_C);
      ticks(2); check_eq("bw_e18_walk", lamps(), WK_C);
      tick();   check_eq("bw_e19_ag", lamps(), AG_C);
      ticks(4); check_eq("bw_e23_ay", lamps(), AY_C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
